hawk_cmpdcmp_rd_mngr: RTL and testbench
=======================================

# hawk_cmpdcmp_rd_mngr

Read-side companion of the compress/decompress write manager in the Hawk memory-compression engine. On a compress/decompress trigger it fetches the source page from memory as single-beat 64-byte AXI reads, at cache-line granularity, and pushes the returned lines in order into the read FIFO that feeds the compressor/decompressor datapath. For compression the source is the 4 KB uncompressed page; for decompression it is the compressed page.

## Interface
- MAX_OUTSTANDING, 4: maximum AR handshakes whose R beats have not yet returned; legal range 1..15.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- cmpdcmp_trigger  in  1  start pulse; sampled in IDLE only
- comp_decomp  in  1  1 = compress (read 64 lines), 0 = decompress (read compressed lines)
- src_addr  in  64  source page byte address, 64 B aligned; bits [5:0] are ignored
- cpage_size  in  13  compressed page size in bytes; used only when comp_decomp = 0
- ar_addr  out  64  read address
- ar_valid  out  1  read address valid
- ar_ready  in  1  read address ready
- r_data  in  512  read data
- r_resp  in  2  read response
- r_valid  in  1  read data valid
- r_ready  out  1  read data ready
- rdfifo_full  in  1  read FIFO full
- rdfifo_push  out  1  FIFO write strobe
- rdfifo_wdata  out  512  FIFO write data
- cmpdcmp_rd_done  out  1  one-cycle pulse after the last line is pushed
- rd_err  out  1  sticky error flag for the current job; cleared on the next trigger

## Operation
- States: IDLE, RD_ISSUE, RD_DRAIN, DONE.
- IDLE → RD_ISSUE on cmpdcmp_trigger. The block latches:
  - base = {src_addr[63:6], 6'b0}
  - n_lines (7 bits): compress = 64. Decompress = (cpage_size + 63) >> 6, clamped to the range 1..64.
  - issue_cnt = 0, rcv_cnt = 0, rd_err = 0.
- RD_ISSUE: ar_valid is asserted when issue_cnt < n_lines and outstanding < MAX_OUTSTANDING. ar_addr = base + 64 × issue_cnt. On an ar_valid && ar_ready handshake, issue_cnt increments. When issue_cnt reaches n_lines → RD_DRAIN.
- r_ready = !rdfifo_full in RD_ISSUE and RD_DRAIN, and 0 in every other state.
- On r_valid && r_ready: rdfifo_push = 1, rdfifo_wdata = r_data, rcv_cnt increments.
- outstanding = issue_cnt − rcv_cnt. When an AR handshake and an R handshake occur in the same cycle, outstanding is unchanged.
- RD_DRAIN → DONE when rcv_cnt reaches n_lines. This includes the cycle in which the final beat is accepted.
- DONE: cmpdcmp_rd_done = 1 for one cycle, then → IDLE.
- A cmpdcmp_trigger that arrives outside IDLE is ignored.

## Timing
- ar_valid, ar_addr and the state are registered. Once ar_valid is asserted, it and ar_addr are held stable until ar_ready.
- The first AR is issued in the cycle after the trigger.
- rdfifo_push and rdfifo_wdata are combinational from the R handshake. Data is pushed in the same cycle it is accepted.
- Best case, with ar_ready and r_valid always high: one line per cycle. cmpdcmp_rd_done occurs N+2 cycles after the trigger.
- Reset values: all outputs 0; ar_addr = 0; state = IDLE.
- Reset mid-job: everything returns to IDLE immediately. R beats still in flight are not tracked; the interconnect is reset together with this block.

## Configuration
- HAWK_CMPDCMP_RD_ERR_CHECK_EN defined:
  - An R handshake with r_resp ≠ 2'b00 sets rd_err.
  - Further AR issue stops: the block moves to RD_DRAIN, and the drain target becomes the current issue_cnt.
  - Erroneous beats are still accepted but are not pushed.
  - cmpdcmp_rd_done pulses once the drain completes; rd_err stays high.
- Undefined: r_resp is ignored and rd_err is tied to 0.

## Structure
- hacd_pkg gains:
  - the state localparam set (as an enum)
  - CACHELINE_BYTES = 64
  - PAGE_LINES = 64
  - a typedef axi_rd_reqpkt_t {addr, arvalid}
  - a typedef axi_rd_resppkt_t {data, resp, rvalid}
- Include hacd_define.vh for the macro.
- No sub-module: the counters and the FSM live in one module.

## Test plan
- Compress, src_addr = 0x1000_0000, ar_ready = 1, r_valid returned one cycle after each AR → 64 pushes in order; ar_addr runs 0x1000_0000..0x1000_0FC0; cmpdcmp_rd_done pulses once.
- Decompress, cpage_size = 1000 → exactly 16 ARs and 16 pushes. cpage_size = 0 → 1 AR. cpage_size = 5000 → clamped to 64.
- r_valid withheld → after 4 ARs, ar_valid stays 0. Release one R beat → exactly one further AR.
- rdfifo_full held high for 10 cycles mid-job → r_ready = 0 and no push; once released, all data arrives intact with no duplicates.
- rst_ni asserted during RD_ISSUE with 3 reads outstanding → all outputs 0 immediately; a new trigger after reset completes normally.
- HAWK_CMPDCMP_RD_ERR_CHECK_EN defined, beat 5 returns r_resp = 2'b10 → no further ARs after those already issued; outstanding reads are drained; rd_err = 1 and cmpdcmp_rd_done pulses.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared types and constants for the Hawk compress/decompress managers.
package hacd_pkg;

  localparam int CACHELINE_BYTES = 64;
  localparam int PAGE_LINES      = 64;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_DRAIN,
    DONE
  } rd_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic        arvalid;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic [511:0] data;
    logic [1:0]   resp;
    logic         rvalid;
  } axi_rd_resppkt_t;

  // Line count of a compressed page: ceil(size / 64), kept within 1..PAGE_LINES.
  function automatic logic [6:0] dcmp_line_cnt(input logic [12:0] size);
    logic [13:0] lines;
    lines = ({1'b0, size} + 14'd63) >> 6;
    if (lines == 14'd0) return 7'd1;
    if (lines > 14'(PAGE_LINES)) return 7'(PAGE_LINES);
    return lines[6:0];
  endfunction

endpackage

// File: rtl/hawk_cmpdcmp_rd_mngr.sv
// Fetches a source page as single-beat 64 B AXI reads and streams the lines into the read FIFO.
// Optional response checking is enabled with HAWK_CMPDCMP_RD_ERR_CHECK_EN.
module hawk_cmpdcmp_rd_mngr
  import hacd_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cmpdcmp_trigger,
  input  logic         comp_decomp,
  input  logic [63:0]  src_addr,
  input  logic [12:0]  cpage_size,
  output logic [63:0]  ar_addr,
  output logic         ar_valid,
  input  logic         ar_ready,
  input  logic [511:0] r_data,
  input  logic [1:0]   r_resp,
  input  logic         r_valid,
  output logic         r_ready,
  input  logic         rdfifo_full,
  output logic         rdfifo_push,
  output logic [511:0] rdfifo_wdata,
  output logic         cmpdcmp_rd_done,
  output logic         rd_err
);

  localparam logic [6:0] MAX_OUT = 7'(MAX_OUTSTANDING);

  rd_state_e       state_reg, state_next;
  logic [63:0]     base_reg, base_next;
  logic [6:0]      n_lines_reg, n_lines_next;
  logic [6:0]      issue_cnt_reg, issue_cnt_next;
  logic [6:0]      rcv_cnt_reg, rcv_cnt_next;
  logic            rd_err_reg, rd_err_next;
  axi_rd_reqpkt_t  ar_req_reg, ar_req_next;
  axi_rd_resppkt_t r_pkt;

  logic ar_hs;
  logic r_hs;
  logic beat_err;
  logic unused_bits;

  assign r_pkt = '{data: r_data, resp: r_resp, rvalid: r_valid};

  assign r_ready = ((state_reg == RD_ISSUE) || (state_reg == RD_DRAIN)) && !rdfifo_full;
  assign ar_hs   = ar_req_reg.arvalid && ar_ready;
  assign r_hs    = r_pkt.rvalid && r_ready;

`ifdef HAWK_CMPDCMP_RD_ERR_CHECK_EN
  assign beat_err    = r_hs && (r_pkt.resp != 2'b00);
  assign unused_bits = ^src_addr[5:0];
`else
  assign beat_err    = 1'b0;
  assign unused_bits = ^{src_addr[5:0], r_pkt.resp};
`endif

  // Erroneous beats are consumed from the bus but never reach the FIFO.
  assign rdfifo_push     = r_hs && !beat_err;
  assign rdfifo_wdata    = rdfifo_push ? r_pkt.data : '0;
  assign ar_valid        = ar_req_reg.arvalid;
  assign ar_addr         = ar_req_reg.addr;
  assign cmpdcmp_rd_done = (state_reg == DONE);
  assign rd_err          = rd_err_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      n_lines_reg   <= '0;
      issue_cnt_reg <= '0;
      rcv_cnt_reg   <= '0;
      rd_err_reg    <= 1'b0;
      ar_req_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      n_lines_reg   <= n_lines_next;
      issue_cnt_reg <= issue_cnt_next;
      rcv_cnt_reg   <= rcv_cnt_next;
      rd_err_reg    <= rd_err_next;
      ar_req_reg    <= ar_req_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    n_lines_next   = n_lines_reg;
    issue_cnt_next = issue_cnt_reg;
    rcv_cnt_next   = rcv_cnt_reg;
    rd_err_next    = rd_err_reg;
    ar_req_next    = ar_req_reg;

    case (state_reg)
      IDLE: begin
        if (cmpdcmp_trigger) begin
          base_next           = {src_addr[63:6], 6'b0};
          n_lines_next        = comp_decomp ? 7'(PAGE_LINES) : dcmp_line_cnt(cpage_size);
          issue_cnt_next      = '0;
          rcv_cnt_next        = '0;
          rd_err_next         = 1'b0;
          state_next          = RD_ISSUE;
          ar_req_next.arvalid = 1'b1;
          ar_req_next.addr    = {src_addr[63:6], 6'b0};
        end
      end

      RD_ISSUE, RD_DRAIN: begin
        if (ar_hs) issue_cnt_next = issue_cnt_reg + 7'd1;
        if (r_hs)  rcv_cnt_next   = rcv_cnt_reg + 7'd1;
        // An error caps the job at what is already on the bus.
        if (beat_err) begin
          rd_err_next  = 1'b1;
          n_lines_next = issue_cnt_next;
        end
        if ((issue_cnt_next == n_lines_next) && (rcv_cnt_next == n_lines_next)) begin
          state_next = DONE;
        end else if (issue_cnt_next == n_lines_next) begin
          state_next = RD_DRAIN;
        end
        // Looking at next-cycle counts keeps AR back-to-back and stable while unacknowledged.
        ar_req_next.arvalid = (state_next == RD_ISSUE) && (issue_cnt_next < n_lines_next) &&
                              ((issue_cnt_next - rcv_cnt_next) < MAX_OUT);
        ar_req_next.addr    = base_reg + 64'(issue_cnt_next) * 64'(CACHELINE_BYTES);
      end

      DONE: begin
        state_next          = IDLE;
        ar_req_next.arvalid = 1'b0;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hawk_cmpdcmp_rd_mngr.sv
// Self-checking bench: table-driven jobs, hand-built corner sequences and randomized jobs.
module tb_hawk_cmpdcmp_rd_mngr;

  localparam int MAX_OUT = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         cmpdcmp_trigger;
  logic         comp_decomp;
  logic [63:0]  src_addr;
  logic [12:0]  cpage_size;
  logic [63:0]  ar_addr;
  logic         ar_valid;
  logic         ar_ready;
  logic [511:0] r_data;
  logic [1:0]   r_resp;
  logic         r_valid;
  logic         r_ready;
  logic         rdfifo_full;
  logic         rdfifo_push;
  logic [511:0] rdfifo_wdata;
  logic         cmpdcmp_rd_done;
  logic         rd_err;

  always #5 clk_i = ~clk_i;

  hawk_cmpdcmp_rd_mngr #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cmpdcmp_trigger(cmpdcmp_trigger),
    .comp_decomp    (comp_decomp),
    .src_addr       (src_addr),
    .cpage_size     (cpage_size),
    .ar_addr        (ar_addr),
    .ar_valid       (ar_valid),
    .ar_ready       (ar_ready),
    .r_data         (r_data),
    .r_resp         (r_resp),
    .r_valid        (r_valid),
    .r_ready        (r_ready),
    .rdfifo_full    (rdfifo_full),
    .rdfifo_push    (rdfifo_push),
    .rdfifo_wdata   (rdfifo_wdata),
    .cmpdcmp_rd_done(cmpdcmp_rd_done),
    .rd_err         (rd_err)
  );

  typedef struct {
    bit          comp;
    logic [63:0] src;
    logic [12:0] csize;
    int          ar_pct;
    int          rv_pct;
    int          full_pct;
    int          exp_lines;
  } vec_t;

  int n_pass   = 0;
  int n_checks = 0;

  // Interconnect / memory model state
  logic [63:0]  pend[$];
  logic [63:0]  ar_log[$];
  logic [511:0] push_log[$];
  int done_cnt, cyc, trig_cyc, done_cyc, max_out, stab_viol;
  int ar_pct, rv_pct, full_pct, r_credit, beat_idx, err_beat;
  int full_viol, rv_stall;
  bit full_force;
  bit prev_ar_wait;
  logic [63:0] prev_ar_addr;

  function automatic logic [511:0] mem_word(input logic [63:0] a);
    logic [511:0] w;
    for (int i = 0; i < 8; i++)
      w[i*64 +: 64] = (a * 64'h9E37_79B9_7F4A_7C15) ^ (64'(i) << 56) ^ a;
    return w;
  endfunction

  function automatic int model_lines(input bit comp, input logic [12:0] size);
    int n;
    if (comp) return 64;
    n = (int'(size) + 63) / 64;
    if (n < 1)  n = 1;
    if (n > 64) n = 64;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // One clock: observe mid-cycle, then drive the next cycle's inputs just after the edge.
  task automatic cycle();
    bit r_hs;
    @(negedge clk_i);
    cyc++;
    if (prev_ar_wait && !(ar_valid && ar_addr == prev_ar_addr)) stab_viol++;
    prev_ar_wait = ar_valid && !ar_ready;
    prev_ar_addr = ar_addr;
    r_hs = r_valid && r_ready;
    if (full_force && (r_ready || rdfifo_push)) full_viol++;
    if (full_force && r_valid) rv_stall++;
    if (ar_valid && ar_ready) begin
      ar_log.push_back(ar_addr);
      pend.push_back(ar_addr);
    end
    if (r_hs) begin
      void'(pend.pop_front());
      if (r_credit > 0) r_credit--;
      beat_idx++;
    end
    if (rdfifo_push) push_log.push_back(rdfifo_wdata);
    if (cmpdcmp_trigger) trig_cyc = cyc;
    if (cmpdcmp_rd_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (pend.size() > max_out) max_out = pend.size();
    @(posedge clk_i);
    #1;
    if (!(r_valid && !r_hs)) begin
      r_valid = 1'b0;
      r_data  = '0;
      r_resp  = 2'b00;
      if (pend.size() > 0 && r_credit != 0 && $urandom_range(0, 99) < rv_pct) begin
        r_valid = 1'b1;
        r_data  = mem_word(pend[0]);
        r_resp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
      end
    end
    ar_ready    = ($urandom_range(0, 99) < ar_pct);
    rdfifo_full = full_force || ($urandom_range(0, 99) < full_pct);
  endtask

  task automatic start_job(input bit comp, input logic [63:0] src, input logic [12:0] size);
    comp_decomp = comp;
    src_addr    = src;
    cpage_size  = size;
    ar_log.delete();
    push_log.delete();
    done_cnt     = 0;
    max_out      = pend.size();
    stab_viol    = 0;
    beat_idx     = 0;
    trig_cyc     = -1;
    done_cyc     = -1;
    prev_ar_wait = 1'b0;
    cmpdcmp_trigger = 1'b1;
    cycle();
    cmpdcmp_trigger = 1'b0;
  endtask

  task automatic finish_job(input string nm, input int exp_ar, input logic [63:0] base,
                            input int skip_beat, input bit exp_err, input bit chk_lat);
    int guard = 0;
    int bad, k, exp_push;
    while (done_cnt == 0 && guard < 4000) begin
      cycle();
      guard++;
    end
    chk({nm, "_done_seen"}, (done_cnt != 0), 1'b1);
    repeat (4) cycle();
    chk({nm, "_ar_cnt"}, ar_log.size(), exp_ar);
    bad = 0;
    foreach (ar_log[i]) if (ar_log[i] !== base + 64'(i) * 64) bad++;
    chk({nm, "_ar_addr_bad"}, bad, 0);
    exp_push = exp_ar - ((skip_beat >= 0 && skip_beat < exp_ar) ? 1 : 0);
    chk({nm, "_push_cnt"}, push_log.size(), exp_push);
    bad = 0;
    k = 0;
    for (int i = 0; i < exp_ar; i++) begin
      if (i == skip_beat) continue;
      if (k < push_log.size() && push_log[k] !== mem_word(base + 64'(i) * 64)) bad++;
      k++;
    end
    chk({nm, "_push_data_bad"}, bad, 0);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_rd_err"}, rd_err, exp_err);
    chk({nm, "_outst_le_max"}, (max_out <= MAX_OUT), 1'b1);
    chk({nm, "_ar_stable"}, stab_viol, 0);
    if (chk_lat) chk({nm, "_done_latency"}, done_cyc - trig_cyc, exp_ar + 2);
    $display("job %s: ars=%0d pushes=%0d done_lat=%0d rd_err=%0b",
             nm, ar_log.size(), push_log.size(), done_cyc - trig_cyc, rd_err);
  endtask

  vec_t vecs[11];

  initial begin
    int n, sz0;
    bit ideal;
    logic [63:0] s;

    vecs[0]  = '{1'b1, 64'h1000_0000,            13'd0,    100, 100, 0,  64};
    vecs[1]  = '{1'b0, 64'h2000_0000,            13'd1000, 100, 100, 0,  16};
    vecs[2]  = '{1'b0, 64'h2100_0000,            13'd0,    100, 100, 0,  1};
    vecs[3]  = '{1'b0, 64'h2200_0000,            13'd5000, 100, 100, 0,  64};
    vecs[4]  = '{1'b0, 64'h2300_0000,            13'd64,   100, 100, 0,  1};
    vecs[5]  = '{1'b0, 64'h2400_0000,            13'd65,   100, 100, 0,  2};
    vecs[6]  = '{1'b0, 64'h2500_123F,            13'd130,  100, 100, 0,  3};
    vecs[7]  = '{1'b0, 64'h2600_0000,            13'd8191, 60,  50,  20, 64};
    vecs[8]  = '{1'b1, 64'hFFFF_FFFF_FFFF_F000,  13'd0,    70,  80,  10, 64};
    vecs[9]  = '{1'b0, 64'h2700_0000,            13'd4033, 100, 100, 0,  64};
    vecs[10] = '{1'b0, 64'h2800_0000,            13'd4032, 100, 100, 0,  63};

    rst_ni = 1'b0;
    cmpdcmp_trigger = 1'b0;
    comp_decomp = 1'b0;
    src_addr = '0;
    cpage_size = '0;
    ar_ready = 1'b0;
    r_valid = 1'b1;
    r_data = '1;
    r_resp = 2'b00;
    rdfifo_full = 1'b0;
    cyc = 0;
    r_credit = -1;
    err_beat = -1;
    full_force = 1'b0;
    full_viol = 0;
    rv_stall = 0;
    ar_pct = 100;
    rv_pct = 100;
    full_pct = 0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_ar_valid", ar_valid, 1'b0);
    chk("reset_ar_addr", ar_addr, 64'h0);
    chk("reset_r_ready", r_ready, 1'b0);
    chk("reset_push", rdfifo_push, 1'b0);
    chk("reset_wdata_nz", (rdfifo_wdata != '0), 1'b0);
    chk("reset_done", cmpdcmp_rd_done, 1'b0);
    chk("reset_rd_err", rd_err, 1'b0);
    r_valid = 1'b0;
    r_data = '0;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Table-driven jobs
    for (int v = 0; v < 11; v++) begin
      ar_pct = vecs[v].ar_pct;
      rv_pct = vecs[v].rv_pct;
      full_pct = vecs[v].full_pct;
      ideal = (ar_pct == 100 && rv_pct == 100 && full_pct == 0);
      start_job(vecs[v].comp, vecs[v].src, vecs[v].csize);
      finish_job($sformatf("vec%0d", v), vecs[v].exp_lines, vecs[v].src & ~64'h3F, -1, 1'b0, ideal);
    end
    ar_pct = 100;
    rv_pct = 100;
    full_pct = 0;

    // Outstanding limit, plus a trigger while busy that must be ignored
    r_credit = 0;
    start_job(1'b1, 64'h3000_0000, 13'd0);
    repeat (12) cycle();
    chk("outst_ar_cnt", ar_log.size(), MAX_OUT);
    chk("outst_ar_valid_low", ar_valid, 1'b0);
    src_addr = 64'h3100_0000;
    cmpdcmp_trigger = 1'b1;
    cycle();
    cmpdcmp_trigger = 1'b0;
    r_credit = 1;
    repeat (10) cycle();
    chk("outst_one_more_ar", ar_log.size(), MAX_OUT + 1);
    chk("outst_one_push", push_log.size(), 1);
    r_credit = -1;
    finish_job("outst", 64, 64'h3000_0000, -1, 1'b0, 1'b0);

    // FIFO full for 10 cycles in the middle of a job
    start_job(1'b1, 64'h3200_0000, 13'd0);
    repeat (20) cycle();
    full_force = 1'b1;
    rdfifo_full = 1'b1;
    full_viol = 0;
    rv_stall = 0;
    sz0 = push_log.size();
    repeat (10) cycle();
    chk("full_no_rready_push", full_viol, 0);
    chk("full_push_frozen", push_log.size(), sz0);
    chk("full_beats_waiting", (rv_stall > 0), 1'b1);
    full_force = 1'b0;
    rdfifo_full = 1'b0;
    finish_job("fifo_full", 64, 64'h3200_0000, -1, 1'b0, 1'b0);

    // Asynchronous reset with reads outstanding, then a clean job
    r_credit = 0;
    start_job(1'b1, 64'h4000_0000, 13'd0);
    n = 0;
    while (ar_log.size() < 3 && n < 50) begin
      cycle();
      n++;
    end
    chk("rst_pre_outstanding", ar_log.size(), 3);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_ar_valid", ar_valid, 1'b0);
    chk("rst_mid_ar_addr", ar_addr, 64'h0);
    chk("rst_mid_r_ready", r_ready, 1'b0);
    chk("rst_mid_push", rdfifo_push, 1'b0);
    chk("rst_mid_done", cmpdcmp_rd_done, 1'b0);
    pend.delete();
    r_valid = 1'b0;
    r_data = '0;
    r_credit = -1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    start_job(1'b0, 64'h4000_1000, 13'd200);
    finish_job("post_rst", 4, 64'h4000_1000, -1, 1'b0, 1'b1);

    // Error response on beat 5
    err_beat = 5;
    start_job(1'b1, 64'h5000_0000, 13'd0);
`ifdef HAWK_CMPDCMP_RD_ERR_CHECK_EN
    finish_job("resp_err", 7, 64'h5000_0000, 5, 1'b1, 1'b0);
`else
    finish_job("resp_ignored", 64, 64'h5000_0000, -1, 1'b0, 1'b1);
`endif
    err_beat = -1;

    // Randomized jobs against the line-count model
    for (int j = 0; j < 16; j++) begin
      bit comp;
      logic [12:0] size;
      comp = 1'($urandom_range(0, 1));
      s = {$urandom, $urandom};
      size = 13'($urandom_range(0, 8191));
      ar_pct = $urandom_range(30, 100);
      rv_pct = $urandom_range(30, 100);
      full_pct = $urandom_range(0, 40);
      n = model_lines(comp, size);
      start_job(comp, s, size);
      finish_job($sformatf("rand%0d", j), n, s & ~64'h3F, -1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
